// File: rtl/board_eval.sv
// board_eval: evaluates N consecutive 64-square boards held in memory and
// reports the best-scoring board for the selected side.
// Optional build macro: EVAL_CENTRE_BONUS_EN adds +/-1 per occupied centre square.
module board_eval (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic [31:0] slave_readdata,
  output logic        slave_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  input  logic        master_waitrequest,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, ACCUM, COMPARE, DONE} state_t;

  state_t             r_state;
  logic [31:0]        r_src;
  logic [31:0]        r_n;
  logic               r_side;
  logic [31:0]        r_board;
  logic [5:0]         r_sq;
  logic [31:0]        r_addr;
  logic               r_mread;
  logic signed [7:0]  r_piece;
  logic signed [15:0] r_score;
  logic [31:0]        r_best_idx;
  logic signed [15:0] r_best_score;

  logic               w_start;
  logic               w_done_read;
  logic               w_better;
  logic signed [15:0] w_delta;
  logic               w_unused_hi;

  // Material value of one piece code, signed by colour.
  function automatic logic signed [15:0] piece_value(input logic signed [7:0] code);
    logic [7:0]         mag;
    logic signed [15:0] v;
    mag = code[7] ? (8'd0 - $unsigned(code)) : $unsigned(code);
    if (mag >= 8'd1 && mag <= 8'd8)        v = 16'sd1;
    else if (mag >= 8'd9 && mag <= 8'd18)  v = 16'sd5;
    else if (mag >= 8'd19 && mag <= 8'd38) v = 16'sd3;
    else if (mag >= 8'd39 && mag <= 8'd47) v = 16'sd9;
    else if (mag == 8'd48)                 v = 16'sd100;
    else                                   v = 16'sd0;
    return code[7] ? -v : v;
  endfunction

`ifdef EVAL_CENTRE_BONUS_EN
  // Extra point for any piece standing on one of the four centre squares.
  function automatic logic signed [15:0] centre_bonus(input logic [5:0] sq,
                                                     input logic signed [7:0] code);
    if (code == 8'sd0) return 16'sd0;
    if (sq != 6'd27 && sq != 6'd28 && sq != 6'd35 && sq != 6'd36) return 16'sd0;
    return code[7] ? -16'sd1 : 16'sd1;
  endfunction
`endif

  assign master_address   = r_addr;
  assign master_read      = r_mread;
  assign master_write     = 1'b0;
  assign master_writedata = 32'd0;
  assign w_unused_hi      = ^master_readdata[31:8];

  assign w_start     = slave_write && (slave_address == 4'd0) && (r_state == IDLE);
  assign w_done_read = slave_read && (slave_address == 4'd0) && (r_state == DONE);
  assign slave_waitrequest = slave_read && (slave_address == 4'd0) && (r_state != DONE);

  // Per-square score contribution of the captured piece.
  always_comb begin
`ifdef EVAL_CENTRE_BONUS_EN
    w_delta = piece_value(r_piece) + centre_bonus(r_sq, r_piece);
`else
    w_delta = piece_value(r_piece);
`endif
  end

  // First board always wins; later boards must be strictly better so ties keep the lower index.
  always_comb begin
    w_better = (r_board == 32'd0) ||
               (r_side ? (r_score > r_best_score) : (r_score < r_best_score));
  end

  // Register read mux; reg 0 only yields data once the evaluation is done.
  always_comb begin
    slave_readdata = 32'd0;
    if (slave_read) begin
      case (slave_address)
        4'd0:    if (r_state == DONE) slave_readdata = r_best_idx;
        4'd1:    slave_readdata = r_src;
        4'd2:    slave_readdata = r_n;
        4'd3:    slave_readdata = {31'd0, r_side};
        4'd5:    slave_readdata = {{16{r_best_score[15]}}, r_best_score};
        default: slave_readdata = 32'd0;
      endcase
    end
  end

  // Configuration registers, writable only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src  <= 32'd0;
      r_n    <= 32'd0;
      r_side <= 1'b0;
    end else if (slave_write && r_state == IDLE) begin
      case (slave_address)
        4'd1:    r_src  <= slave_writedata;
        4'd2:    r_n    <= slave_writedata;
        4'd3:    r_side <= slave_writedata[0];
        default: ;
      endcase
    end
  end

  // Evaluation FSM: one outstanding byte read per square, address walks linearly across boards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mread      <= 1'b0;
      r_addr       <= 32'd0;
      r_board      <= 32'd0;
      r_sq         <= 6'd0;
      r_piece      <= 8'sd0;
      r_score      <= 16'sd0;
      r_best_idx   <= 32'hFFFF_FFFF;
      r_best_score <= 16'sd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_board      <= 32'd0;
            r_sq         <= 6'd0;
            r_score      <= 16'sd0;
            r_best_idx   <= 32'hFFFF_FFFF;
            r_best_score <= 16'sd0;
            r_addr       <= r_src;
            if (r_n == 32'd0) begin
              r_state <= DONE;
            end else begin
              r_mread <= 1'b1;
              r_state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (!master_waitrequest) begin
            r_mread <= 1'b0;
            r_state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (master_readdatavalid) begin
            r_piece <= $signed(master_readdata[7:0]);
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          r_score <= r_score + w_delta;
          r_addr  <= r_addr + 32'd1;
          if (r_sq == 6'd63) begin
            r_state <= COMPARE;
          end else begin
            r_sq    <= r_sq + 6'd1;
            r_mread <= 1'b1;
            r_state <= FETCH;
          end
        end
        COMPARE: begin
          if (w_better) begin
            r_best_idx   <= r_board;
            r_best_score <= r_score;
          end
          r_score <= 16'sd0;
          r_sq    <= 6'd0;
          if (r_board == r_n - 32'd1) begin
            r_state <= DONE;
          end else begin
            r_board <= r_board + 32'd1;
            r_mread <= 1'b1;
            r_state <= FETCH;
          end
        end
        DONE: begin
          if (w_done_read) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_eval.sv
// tb_board_eval: directed vectors for board_eval against a byte-memory model.
module tb_board_eval;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic [31:0] slave_readdata;
  logic        slave_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_waitrequest;
  logic        master_write;
  logic [31:0] master_writedata;

  logic [7:0]  mem [0:255];
  int          stall_cfg   = 0;
  int          stall_cnt   = 0;
  int          n_reads     = 0;
  int          addr_glitch = 0;
  logic [31:0] hold_addr   = 32'd0;
  logic        rdv         = 1'b0;
  logic        stray       = 1'b0;
  logic [31:0] rdata       = 32'd0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  board_eval dut (
    .clk                  (clk),
    .rst                  (rst),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .slave_readdata       (slave_readdata),
    .slave_waitrequest    (slave_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_waitrequest   (master_waitrequest),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  assign master_waitrequest   = master_read && (stall_cnt < stall_cfg);
  assign master_readdatavalid = rdv | stray;
  assign master_readdata      = rdata;

  // Memory model: stalls each read stall_cfg cycles, returns data one cycle after acceptance.
  always @(posedge clk) begin
    rdv <= 1'b0;
    if (master_read) begin
      if (stall_cnt != 0 && master_address != hold_addr) addr_glitch <= addr_glitch + 1;
      if (stall_cnt == 0) hold_addr <= master_address;
      if (master_waitrequest) begin
        stall_cnt <= stall_cnt + 1;
      end else begin
        stall_cnt <= 0;
        rdv       <= 1'b1;
        rdata     <= {24'h0, mem[master_address[7:0]]};
        n_reads   <= n_reads + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address   = a;
    slave_writedata = d;
    slave_write     = 1'b1;
    @(negedge clk);
    slave_write     = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input int budget, output logic [31:0] d, output int cyc);
    @(negedge clk);
    slave_address = a;
    slave_read    = 1'b1;
    cyc = 0;
    d   = 32'hDEAD_BEEF;
    #1;
    while (slave_waitrequest && cyc < budget) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (!slave_waitrequest) d = slave_readdata;
    @(negedge clk);
    slave_read = 1'b0;
  endtask

  task automatic evaluate(input logic [31:0] n, input logic side,
                          output logic [31:0] idx, output logic [31:0] score,
                          output int cyc, output int reads);
    int r0;
    int c5;
    r0 = n_reads;
    wr(4'd1, 32'h0000_1000);
    wr(4'd2, n);
    wr(4'd3, {31'd0, side});
    wr(4'd0, 32'h1234_5678);
    rd(4'd0, 20000, idx, cyc);
    rd(4'd5, 2, score, c5);
    reads = n_reads - r0;
  endtask

  initial begin
    logic [31:0] idx, score, d;
    int cyc, reads, c, g0;

    rst = 1'b1;
    slave_address = 4'd0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = 32'd0;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mread", {31'd0, master_read}, 32'd0);
    chk("rst_maddr", master_address, 32'd0);
    chk("rst_swait", {31'd0, slave_waitrequest}, 32'd0);
    chk("rst_srdata", slave_readdata, 32'd0);
    chk("rst_mwrite", {31'd0, master_write}, 32'd0);
    chk("rst_mwdata", master_writedata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(4'd2, 2, d, c); chk("rst_reg2", d, 32'd0);
    rd(4'd5, 2, d, c); chk("rst_reg5", d, 32'd0);

    // Empty board vs. board with a white queen
    mem[64] = 8'd39;
    evaluate(32'd2, 1'b1, idx, score, cyc, reads);
    chk("wq_w_idx", idx, 32'd1);
    chk("wq_w_score", score, 32'd9);
    chk("wq_w_reads", reads, 32'd128);
    rd(4'd1, 2, d, c); chk("reg1_rb", d, 32'h0000_1000);
    rd(4'd4, 2, d, c); chk("reg4_zero", d, 32'd0);

    evaluate(32'd2, 1'b0, idx, score, cyc, reads);
    chk("wq_b_idx", idx, 32'd0);
    chk("wq_b_score", score, 32'd0);

    // Three identical boards with a black rook: tie keeps lowest index
    clear_mem();
    mem[5] = 8'hF7; mem[69] = 8'hF7; mem[133] = 8'hF7;
    evaluate(32'd3, 1'b1, idx, score, cyc, reads);
    chk("tie_idx", idx, 32'd0);
    chk("tie_score", score, 32'hFFFF_FFFB);

    // N = 0
    evaluate(32'd0, 1'b1, idx, score, cyc, reads);
    chk("n0_idx", idx, 32'hFFFF_FFFF);
    chk("n0_lat", {31'd0, (cyc <= 3)}, 32'd1);
    chk("n0_reads", reads, 32'd0);
    chk("n0_score", score, 32'd0);

    // Memory stalls 5 cycles on every read
    clear_mem();
    mem[64] = 8'd39;
    stall_cfg = 5;
    g0 = addr_glitch;
    evaluate(32'd2, 1'b1, idx, score, cyc, reads);
    stall_cfg = 0;
    chk("stall_idx", idx, 32'd1);
    chk("stall_score", score, 32'd9);
    chk("stall_reads", reads, 32'd128);
    chk("stall_addr_stable", addr_glitch - g0, 32'd0);

    // Piece table boundaries; board1 holds a black queen
    clear_mem();
    mem[0] = 8'd8;  mem[1] = 8'd9;  mem[2] = 8'd18; mem[3] = 8'd19;
    mem[4] = 8'd28; mem[5] = 8'd29; mem[6] = 8'd38; mem[7] = 8'd47;
    mem[8] = 8'd48; mem[9] = 8'hD0; mem[10] = 8'hFF; mem[11] = 8'd49;
    mem[127] = 8'hD9;
    evaluate(32'd2, 1'b0, idx, score, cyc, reads);
    chk("tbl_b_idx", idx, 32'd1);
    chk("tbl_b_score", score, 32'hFFFF_FFF7);
    evaluate(32'd1, 1'b1, idx, score, cyc, reads);
    chk("tbl_w_idx", idx, 32'd0);
    chk("tbl_w_score", score, 32'd31);

    // White pawn on a centre square
    clear_mem();
    mem[27] = 8'd1;
    evaluate(32'd1, 1'b1, idx, score, cyc, reads);
    chk("centre_idx", idx, 32'd0);
`ifdef EVAL_CENTRE_BONUS_EN
    chk("centre_score", score, 32'd2);
`else
    chk("centre_score", score, 32'd1);
`endif

    // Reset in the middle of an evaluation
    clear_mem();
    mem[64] = 8'd39;
    wr(4'd1, 32'h0000_1000);
    wr(4'd2, 32'd2);
    wr(4'd3, 32'd1);
    wr(4'd0, 32'd0);
    repeat (40) @(negedge clk);
    c = 0;
    while (!master_read && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("mid_mread_seen", {31'd0, master_read}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_mread", {31'd0, master_read}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    rd(4'd2, 2, d, c); chk("mid_reg2", d, 32'd0);
    rd(4'd3, 2, d, c); chk("mid_reg3", d, 32'd0);
    rd(4'd5, 2, d, c); chk("mid_reg5", d, 32'd0);
    evaluate(32'd0, 1'b1, idx, score, cyc, reads);
    chk("mid_n0_idx", idx, 32'hFFFF_FFFF);
    chk("mid_n0_score", score, 32'd0);
    chk("mid_n0_reads", reads, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/board_eval.md
BOARD_EVAL -- requirements
Module: board_eval

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 slave_address  in  4  register select; slave_read/slave_write in 1 each; slave_writedata in 32; slave_readdata out 32; slave_waitrequest out 1.
REQ-004 master_address  out  32  byte address of board square; master_read out 1; master_readdata in 32 (bits [7:0] = signed piece code); master_readdatavalid in 1; master_waitrequest in 1.
REQ-005 master_write out 1 and master_writedata out 32 SHALL be tied 0; block never writes memory.
REQ-006 Registers: 0 start(write)/best index(read), 1 src base address, 2 board count N, 3 side (1 = white maximises, 0 = black minimises), 5 best score (read, sign-extended).

Function
REQ-007 Boards SHALL be 64 consecutive bytes; board k occupies src+64k .. src+64k+63.
REQ-008 Piece value by |code|: 1-8 = 1, 9-18 = 5, 19-28 = 3, 29-38 = 3, 39-47 = 9, 48 = 100, 0 = 0; positive codes add, negative codes subtract.
REQ-009 Score SHALL be 16-bit signed accumulator, cleared per board; no saturation needed (range fits).
REQ-010 FSM states: IDLE, FETCH, WAIT_DATA, ACCUM, COMPARE, DONE.
REQ-011 IDLE -> FETCH on write to reg 0 (data ignored); board index and square counter cleared, best index = 0xFFFFFFFF.
REQ-012 FETCH: hold master_read=1 and address until master_waitrequest=0, then -> WAIT_DATA with master_read=0.
REQ-013 WAIT_DATA: on master_readdatavalid=1 capture readdata[7:0] -> ACCUM; exactly one read outstanding.
REQ-014 ACCUM: add value; square 63 -> COMPARE, else square+1 -> FETCH.
REQ-015 COMPARE: side 1 keeps strictly greater score, side 0 strictly smaller; first board always taken; ties keep lower index.
REQ-016 After board N-1 -> DONE; else next board -> FETCH.
REQ-017 N = 0: start goes directly to DONE, best index 0xFFFFFFFF, best score 0, no master reads.
REQ-018 Read of reg 0 SHALL hold slave_waitrequest=1 until DONE, then return best index with waitrequest=0 and return FSM to IDLE.
REQ-019 All other slave accesses complete with waitrequest=0 in the same cycle; writes to regs 1-3 or 0 while not IDLE are ignored.
REQ-020 Reads of unused registers return 0.

Reset
REQ-021 On rst: FSM = IDLE, master_read = 0, master_address = 0, slave_waitrequest = 0, slave_readdata = 0, regs 1-3 = 0, best index = 0xFFFFFFFF, best score = 0.
REQ-022 rst asserted mid-evaluation SHALL abort immediately; any pending readdatavalid after release is ignored.

Configuration
REQ-023 Macro EVAL_CENTRE_BONUS_EN: when defined, each non-empty piece on squares 27, 28, 35, 36 adds +1 for its colour (+1 white, -1 black) on top of REQ-008.
REQ-024 Without EVAL_CENTRE_BONUS_EN scoring is exactly REQ-008; no bonus logic synthesised.

Verification
REQ-025 Board0 all empty, board1 one WQUEEN0 (39) at square 0, N=2, side=1 -> reg0 = 1, reg5 = 9.
REQ-026 Same two boards, side=0 -> reg0 = 0, reg5 = 0.
REQ-027 Three identical boards with one BROOK0 (-9), side=1 -> reg0 = 0 (tie to lowest), reg5 = -5 (0xFFFFFFFB).
REQ-028 N=0, start, read reg0 -> 0xFFFFFFFF within 3 cycles, zero master reads.
REQ-029 master_waitrequest held 1 for 5 cycles on every read -> address stable throughout, result unchanged vs. REQ-025.
REQ-030 WPAWN0 (1) at square 27, macro defined -> reg5 = 2; macro undefined -> reg5 = 1; rst mid-run -> master_read = 0 next cycle, reg0 read then returns 0xFFFFFFFF after new start with N=0.
